// File: rtl/hazard_pkg.sv
// Shared types, constants and small counter helpers for the register hazard scoreboard.
package hazard_pkg;
   localparam int SB_NREG  = 34;
   localparam int SB_IDX_W = 6;
   localparam int SB_LAT_W = 5;
   localparam int REG_HI   = 32;
   localparam int REG_LO   = 33;

   typedef struct packed {
      logic                use_rs;
      logic                use_rt;
      logic                at_id;
      logic                wr;
      logic                wr2;
      logic [SB_IDX_W-1:0] rs;
      logic [SB_IDX_W-1:0] rt;
      logic [SB_IDX_W-1:0] rw;
      logic [SB_IDX_W-1:0] rw2;
      logic [SB_LAT_W-1:0] lat;
   } type_SB_REQ;

   // Destinations of the instruction now in EX, with their counters from just before it issued.
   typedef struct packed {
      logic                valid;
      logic [SB_IDX_W-1:0] d;
      logic [SB_IDX_W-1:0] d2;
      logic [SB_LAT_W-1:0] c1;
      logic [SB_LAT_W-1:0] c2;
   } type_SB_UNDO;

   function automatic logic [SB_LAT_W-1:0] sat_dec(input logic [SB_LAT_W-1:0] v);
      return (v == {SB_LAT_W{1'b0}}) ? v : v - {{(SB_LAT_W-1){1'b0}}, 1'b1};
   endfunction

   function automatic logic [SB_LAT_W-1:0] eff_lat(input logic [SB_LAT_W-1:0] v);
      return (v == {SB_LAT_W{1'b0}}) ? {{(SB_LAT_W-1){1'b0}}, 1'b1} : v;
   endfunction
endpackage

// File: rtl/hazard_scoreboard_counter.sv
// sb_counter: one saturating down-counter per tracked register, with load and undo-restore.
module sb_counter #(
   parameter int LAT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             load,
   input  logic [LAT_W-1:0] load_val,
   input  logic             restore,
   input  logic [LAT_W-1:0] restore_val,
   output logic [LAT_W-1:0] cnt
);
   localparam logic [LAT_W-1:0] ONE = {{(LAT_W-1){1'b0}}, 1'b1};

   // Priority: reset, global clear, undo restore, issue load, free-running countdown.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= {LAT_W{1'b0}};
      end else if (clr) begin
         cnt <= {LAT_W{1'b0}};
      end else if (restore) begin
         cnt <= restore_val;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != {LAT_W{1'b0}}) begin
         cnt <= cnt - ONE;
      end else begin
         cnt <= cnt;
      end
   end
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register pending-write countdowns driving RAW/WAW stalls for the ID stage,
// with a one-deep undo record so a killed EX instruction leaves no residue.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int NREG  = SB_NREG,
   parameter int IDX_W = SB_IDX_W,
   parameter int LAT_W = SB_LAT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [IDX_W-1:0] id_rs,
   input  logic [IDX_W-1:0] id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic             id_at_id,
   input  logic             id_wr,
   input  logic [IDX_W-1:0] id_rw,
   input  logic             id_wr2,
   input  logic [IDX_W-1:0] id_rw2,
   input  logic [LAT_W-1:0] id_lat,
   input  logic             ex_flush,
   input  logic             flush_all,
   output logic             stall,
   output logic             stall_raw,
   output logic             stall_waw,
   output logic             busy
);
   type_SB_REQ       req_s;
   type_SB_UNDO      undo_r;
   logic [LAT_W-1:0] cnt_s [NREG];
   logic [NREG-1:0]  raw_v_s, waw_v_s, nz_v_s;
   logic [LAT_W-1:0] lat_s, thr_s, pre_c1_s, pre_c2_s;
   logic [IDX_W-1:0] rec_d_s, rec_d2_s;
   logic             gate_s, raw_s, waw_s, issue_s;

   assign req_s = {id_use_rs, id_use_rt, id_at_id, id_wr, id_wr2,
                   id_rs, id_rt, id_rw, id_rw2, id_lat};

   assign lat_s  = eff_lat(req_s.lat);
   assign thr_s  = req_s.at_id ? {LAT_W{1'b0}} : {{(LAT_W-1){1'b0}}, 1'b1};
   assign raw_s  = |raw_v_s;
   assign waw_s  = |waw_v_s;
   assign gate_s = id_valid && !ex_flush && !flush_all;
   assign issue_s = gate_s && !(raw_s || waw_s);

   assign stall     = gate_s && (raw_s || waw_s);
   assign stall_raw = gate_s && raw_s;
   assign stall_waw = gate_s && waw_s;
   assign busy      = |nz_v_s;

   // Index 0 is hardwired zero and never pending.
   assign cnt_s[0]   = {LAT_W{1'b0}};
   assign raw_v_s[0] = 1'b0;
   assign waw_v_s[0] = 1'b0;
   assign nz_v_s[0]  = 1'b0;

   for (genvar i = 1; i < NREG; i++) begin : g_reg
      localparam logic [IDX_W-1:0] IDX = IDX_W'(i);
      logic src_hit_s, dst_hit_s, undo_hit_s;
      logic [LAT_W-1:0] rest_val_s;

      assign src_hit_s  = (req_s.use_rs && req_s.rs == IDX) || (req_s.use_rt && req_s.rt == IDX);
      assign dst_hit_s  = (req_s.wr && req_s.rw == IDX) || (req_s.wr2 && req_s.rw2 == IDX);
      assign undo_hit_s = undo_r.valid && (undo_r.d == IDX || undo_r.d2 == IDX);
      assign rest_val_s = (undo_r.d == IDX) ? sat_dec(undo_r.c1) : sat_dec(undo_r.c2);
      assign raw_v_s[i] = src_hit_s && (cnt_s[i] > thr_s);
      assign waw_v_s[i] = dst_hit_s && (cnt_s[i] > lat_s);
      assign nz_v_s[i]  = (cnt_s[i] != {LAT_W{1'b0}});

      sb_counter #(.LAT_W(LAT_W)) u_cnt (
         .clk         (clk),
         .rst_n       (rst_n),
         .clr         (flush_all),
         .load        (issue_s && dst_hit_s),
         .load_val    (lat_s),
         .restore     (ex_flush && undo_hit_s),
         .restore_val (rest_val_s),
         .cnt         (cnt_s[i])
      );
   end

   assign rec_d_s  = req_s.wr  ? req_s.rw  : {IDX_W{1'b0}};
   assign rec_d2_s = req_s.wr2 ? req_s.rw2 : {IDX_W{1'b0}};

   // Pre-issue counter values of the destinations, captured into the undo record.
   always_comb begin
      pre_c1_s = {LAT_W{1'b0}};
      pre_c2_s = {LAT_W{1'b0}};
      for (int i = 1; i < NREG; i++) begin
         pre_c1_s = pre_c1_s | ((rec_d_s  == IDX_W'(i)) ? cnt_s[i] : {LAT_W{1'b0}});
         pre_c2_s = pre_c2_s | ((rec_d2_s == IDX_W'(i)) ? cnt_s[i] : {LAT_W{1'b0}});
      end
   end

   // Undo record lives exactly one cycle: valid only while its instruction sits in EX.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         undo_r <= '0;
      end else if (issue_s) begin
         undo_r <= {1'b1, rec_d_s, rec_d2_s, pre_c1_s, pre_c2_s};
      end else begin
         undo_r <= '0;
      end
   end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed table, multi-cycle corner sequences and a random stream against a reference model.
module tb_hazard_scoreboard;
   import hazard_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic id_valid = 1'b0, ex_flush = 1'b0, flush_all = 1'b0;
   type_SB_REQ req = '0;
   logic [SB_IDX_W-1:0] id_rs, id_rt, id_rw, id_rw2;
   logic [SB_LAT_W-1:0] id_lat;
   logic id_use_rs, id_use_rt, id_at_id, id_wr, id_wr2;
   logic stall, stall_raw, stall_waw, busy;

   assign id_rs = req.rs;   assign id_rt = req.rt;
   assign id_rw = req.rw;   assign id_rw2 = req.rw2;
   assign id_lat = req.lat; assign id_use_rs = req.use_rs;
   assign id_use_rt = req.use_rt; assign id_at_id = req.at_id;
   assign id_wr = req.wr;   assign id_wr2 = req.wr2;

   hazard_scoreboard dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_at_id(id_at_id),
      .id_wr(id_wr), .id_rw(id_rw), .id_wr2(id_wr2), .id_rw2(id_rw2), .id_lat(id_lat),
      .ex_flush(ex_flush), .flush_all(flush_all),
      .stall(stall), .stall_raw(stall_raw), .stall_waw(stall_waw), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail = 0;
   int m_cnt [64];
   bit m_uv;
   int m_ud, m_ud2, m_uc, m_uc2;
   logic obs_stall, obs_raw, obs_waw, obs_busy;

   typedef struct {
      logic       valid;
      type_SB_REQ req;
      logic       e_stall, e_raw, e_waw, e_busy;
   } vec_t;
   vec_t tbl [14];

   task automatic check(input string nm, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic type_SB_REQ mkreq(input bit urs, input int rs, input bit urt, input int rt,
                                        input bit at, input bit w, input int rw,
                                        input bit w2, input int rw2, input int lat);
      type_SB_REQ r;
      r.use_rs = urs; r.use_rt = urt; r.at_id = at; r.wr = w; r.wr2 = w2;
      r.rs = SB_IDX_W'(rs); r.rt = SB_IDX_W'(rt);
      r.rw = SB_IDX_W'(rw); r.rw2 = SB_IDX_W'(rw2);
      r.lat = SB_LAT_W'(lat);
      return r;
   endfunction

   function automatic vec_t mk(input bit v, input type_SB_REQ r,
                               input bit es, input bit er, input bit ew, input bit eb);
      vec_t t;
      t.valid = v; t.req = r;
      t.e_stall = es; t.e_raw = er; t.e_waw = ew; t.e_busy = eb;
      return t;
   endfunction

   task automatic set_idle();
      id_valid = 1'b0; ex_flush = 1'b0; flush_all = 1'b0; req = '0;
   endtask

   task automatic issue(input type_SB_REQ r);
      id_valid = 1'b1; ex_flush = 1'b0; flush_all = 1'b0; req = r;
   endtask

   // One clock: compare outputs with the reference model, then advance both.
   task automatic tick();
      int  thr, leff;
      bit  raw, waw, gate, iss, mbusy;
      int  nxt [64];
      #2;
      leff = (req.lat == 0) ? 1 : int'(req.lat);
      thr  = req.at_id ? 0 : 1;
      raw  = (req.use_rs && req.rs != 0 && m_cnt[req.rs] > thr) ||
             (req.use_rt && req.rt != 0 && m_cnt[req.rt] > thr);
      waw  = (req.wr  && req.rw  != 0 && m_cnt[req.rw]  > leff) ||
             (req.wr2 && req.rw2 != 0 && m_cnt[req.rw2] > leff);
      gate = id_valid && !ex_flush && !flush_all;
      mbusy = 1'b0;
      for (int i = 0; i < 64; i++) if (m_cnt[i] != 0) mbusy = 1'b1;
      obs_stall = stall; obs_raw = stall_raw; obs_waw = stall_waw; obs_busy = busy;
      check("model_stall", int'(stall), int'(gate && (raw || waw)));
      check("model_raw",   int'(stall_raw), int'(gate && raw));
      check("model_waw",   int'(stall_waw), int'(gate && waw));
      check("model_busy",  int'(busy), int'(mbusy));
      iss = gate && !(raw || waw);
      for (int i = 0; i < 64; i++) nxt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
      if (!rst_n || flush_all) begin
         for (int i = 0; i < 64; i++) nxt[i] = 0;
         m_uv = 1'b0;
      end else if (ex_flush) begin
         if (m_uv) begin
            if (m_ud2 != 0) nxt[m_ud2] = (m_uc2 > 0) ? m_uc2 - 1 : 0;
            if (m_ud  != 0) nxt[m_ud]  = (m_uc  > 0) ? m_uc  - 1 : 0;
         end
         m_uv = 1'b0;
      end else if (iss) begin
         m_ud  = req.wr  ? int'(req.rw)  : 0;
         m_ud2 = req.wr2 ? int'(req.rw2) : 0;
         m_uc  = m_cnt[m_ud];
         m_uc2 = m_cnt[m_ud2];
         m_uv  = 1'b1;
         if (m_ud  != 0) nxt[m_ud]  = leff;
         if (m_ud2 != 0) nxt[m_ud2] = leff;
      end else begin
         m_uv = 1'b0;
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 64; i++) m_cnt[i] = nxt[i];
   endtask

   task automatic drain();
      set_idle();
      for (int k = 0; k < 40; k++) begin
         tick();
         if (!obs_busy) break;
      end
      check("drain_busy", int'(obs_busy), 0);
   endtask

   // Present r repeatedly until it issues; returns number of stall cycles (bounded).
   task automatic count_stalls(input type_SB_REQ r, output int n);
      n = 0;
      issue(r);
      for (int k = 0; k < 40; k++) begin
         tick();
         if (obs_stall) n++;
         else break;
      end
      set_idle();
   endtask

   int n;
   type_SB_REQ div_r, mfhi_r;

   initial begin
      for (int i = 0; i < 64; i++) m_cnt[i] = 0;
      m_uv = 1'b0; m_ud = 0; m_ud2 = 0; m_uc = 0; m_uc2 = 0;
      div_r  = mkreq(0, 0, 0, 0, 0, 1, REG_HI, 1, REG_LO, 20);
      mfhi_r = mkreq(1, REG_HI, 0, 0, 0, 1, 8, 0, 0, 1);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      tbl[0]  = mk(0, mkreq(0, 0, 0, 0, 0, 0, 0, 0, 0, 0),   0, 0, 0, 0);
      tbl[1]  = mk(1, mkreq(0, 0, 0, 0, 0, 1, 8, 0, 0, 2),   0, 0, 0, 0);
      tbl[2]  = mk(1, mkreq(1, 8, 0, 0, 0, 1, 10, 0, 0, 1),  1, 1, 0, 1);
      tbl[3]  = mk(1, mkreq(1, 8, 0, 0, 0, 1, 10, 0, 0, 1),  0, 0, 0, 1);
      tbl[4]  = mk(0, mkreq(0, 0, 0, 0, 0, 0, 0, 0, 0, 0),   0, 0, 0, 1);
      tbl[5]  = mk(0, mkreq(0, 0, 0, 0, 0, 0, 0, 0, 0, 0),   0, 0, 0, 0);
      tbl[6]  = mk(1, mkreq(0, 0, 0, 0, 0, 1, 9, 0, 0, 1),   0, 0, 0, 0);
      tbl[7]  = mk(1, mkreq(1, 9, 0, 0, 1, 0, 0, 0, 0, 0),   1, 1, 0, 1);
      tbl[8]  = mk(1, mkreq(1, 9, 0, 0, 1, 0, 0, 0, 0, 0),   0, 0, 0, 0);
      tbl[9]  = mk(1, mkreq(0, 0, 0, 0, 0, 1, 0, 0, 0, 5),   0, 0, 0, 0);
      tbl[10] = mk(1, mkreq(1, 0, 1, 0, 1, 0, 0, 0, 0, 0),   0, 0, 0, 0);
      tbl[11] = mk(1, mkreq(0, 0, 0, 0, 0, 1, 11, 0, 0, 0),  0, 0, 0, 0);
      tbl[12] = mk(1, mkreq(1, 11, 0, 0, 0, 0, 0, 0, 0, 1),  0, 0, 0, 1);
      tbl[13] = mk(0, mkreq(0, 0, 0, 0, 0, 0, 0, 0, 0, 0),   0, 0, 0, 0);

      for (int r = 0; r < 14; r++) begin
         id_valid = tbl[r].valid; ex_flush = 1'b0; flush_all = 1'b0; req = tbl[r].req;
         tick();
         check($sformatf("vec%0d_stall", r), int'(obs_stall), int'(tbl[r].e_stall));
         check($sformatf("vec%0d_raw", r),   int'(obs_raw),   int'(tbl[r].e_raw));
         check($sformatf("vec%0d_waw", r),   int'(obs_waw),   int'(tbl[r].e_waw));
         check($sformatf("vec%0d_busy", r),  int'(obs_busy),  int'(tbl[r].e_busy));
      end

      // MD followed by mtlo: ordering stall until LO counter reaches 1
      drain();
      issue(div_r); tick();
      count_stalls(mkreq(0, 0, 0, 0, 0, 1, REG_LO, 0, 0, 1), n);
      check("mtlo_waw_cycles", n, 19);
      drain();
      issue(div_r); tick();
      issue(mkreq(0, 0, 0, 0, 0, 1, REG_LO, 0, 0, 1)); tick();
      check("mtlo_waw_flag", int'(obs_waw), 1);
      check("mtlo_raw_flag", int'(obs_raw), 0);
      drain();

      // MD followed by mfhi: 19 source stalls
      issue(div_r); tick();
      issue(mfhi_r); tick();
      check("mfhi_raw_flag", int'(obs_raw), 1);
      count_stalls(mfhi_r, n);
      check("mfhi_raw_cycles", n + 1, 19);
      drain();

      // EX flush restores the pre-issue counter minus one
      issue(mkreq(0, 0, 0, 0, 0, 1, 5, 0, 0, 4)); tick();
      set_idle(); tick();
      issue(mkreq(0, 0, 0, 0, 0, 1, 5, 0, 0, 4)); tick();
      check("undo_issue_stall", int'(obs_stall), 0);
      issue(mkreq(1, 5, 0, 0, 0, 1, 6, 0, 0, 1)); ex_flush = 1'b1; tick();
      check("undo_flush_stall", int'(obs_stall), 0);
      count_stalls(mkreq(1, 5, 0, 0, 0, 0, 0, 0, 0, 1), n);
      check("undo_probe_stalls", n, 1);
      tick();
      check("undo_no_residue", int'(obs_busy), 0);

      // Same destination twice makes a single entry
      drain();
      issue(mkreq(0, 0, 0, 0, 0, 1, 12, 1, 12, 3)); tick();
      count_stalls(mkreq(1, 12, 0, 0, 0, 0, 0, 0, 0, 1), n);
      check("dup_dest_stalls", n, 2);

      // flush_all during a long divide
      drain();
      issue(div_r); tick();
      set_idle(); repeat (3) tick();
      issue(mfhi_r); flush_all = 1'b1; tick();
      check("flush_all_stall", int'(obs_stall), 0);
      flush_all = 1'b0; tick();
      check("flush_all_busy", int'(obs_busy), 0);
      check("flush_all_mfhi", int'(obs_stall), 0);

      // Reset in the middle of a divide
      drain();
      issue(div_r); tick();
      set_idle(); repeat (2) tick();
      rst_n = 1'b0; tick();
      rst_n = 1'b1;
      issue(mfhi_r); tick();
      check("rst_stall", int'(obs_stall), 0);
      check("rst_raw",   int'(obs_raw), 0);
      check("rst_waw",   int'(obs_waw), 0);
      check("rst_busy",  int'(obs_busy), 0);

      // Random stream against the model
      for (int k = 0; k < 400; k++) begin
         int idx [6];
         idx[0] = 0; idx[1] = 1; idx[2] = 2; idx[3] = 3; idx[4] = REG_HI; idx[5] = REG_LO;
         req = mkreq($urandom_range(0, 1), idx[$urandom_range(0, 5)],
                     $urandom_range(0, 1), idx[$urandom_range(0, 5)],
                     $urandom_range(0, 1), $urandom_range(0, 1), idx[$urandom_range(0, 5)],
                     $urandom_range(0, 1), idx[$urandom_range(0, 5)],
                     ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 4));
         id_valid  = ($urandom_range(0, 3) != 0);
         ex_flush  = ($urandom_range(0, 9) == 0);
         flush_all = ($urandom_range(0, 29) == 0);
         tick();
      end
      set_idle();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
